aes_job_scheduler: RTL and testbench

- Sequences the shared AES cores (ASMD_Encryption / ASMD_Decryption) on behalf of two requesters.
- Requesters: SD write path (plaintext to be encrypted before storage) and SD read path (ciphertext to be decrypted after readback).
- Arbitrates round-robin, owns the one-cycle start pulse, waits for done with a timeout, captures Dout, and returns the result to the winning requester.
- Only one AES operation is in flight at a time, so key_in is stable for the whole operation.

---
 rtl/aes_sched_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/aes_job_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg
//   Shared types and constants for the AES job scheduler slice.
//   - sched_state_t : scheduler FSM encoding (VSTART/VWAIT exist only for
//                     the round-trip self-check build, AES_ROUNDTRIP_CHECK_EN)
//   - OP_ENC/OP_DEC : selected-operation flag values
//   - AES_BLK_W     : AES block width in bits
package aes_sched_pkg;

    localparam int AES_BLK_W = 128;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESULT,
        VSTART,
        VWAIT
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin arbiter. Grant is combinational from req and
//   the registered priority pointer; the pointer moves to the side opposite
//   the grant whenever update is asserted with a grant present.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high; pointer favours req[0]
//   req    : request vector, bit 0 = write path, bit 1 = read path
//   update : commit the current grant (advance the pointer)
//   grant  : one-hot grant (or zero when no request)
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 0: req[0] wins a tie, 1: req[1] wins a tie
    logic ptr_q;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            // after granting side 0, favour side 1 next time, and vice versa
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
//   Sequences the shared AES encrypt/decrypt cores for two requesters: the
//   SD write path (encrypt) and the SD read path (decrypt). One operation is
//   in flight at a time: round-robin grant, one-cycle core start pulse,
//   wait for the rising edge of done under a timeout, capture Dout, and hold
//   the result until the requester accepts it.
//
//   Optional build macro AES_ROUNDTRIP_CHECK_EN: after each encryption the
//   ciphertext is decrypted again and compared with the plaintext; a
//   mismatch sets the sticky roundtrip_err output. wr_res_valid rises only
//   once that check has finished.
//
// Ports:
//   clock, reset                 : clock (rising edge), async active-high reset
//   key                          : AES key, wired straight to the cores' key_in
//                                  outside this block
//   wr_req/wr_data/wr_ack        : encrypt request, plaintext, 1-cycle accept
//   wr_res_valid/ready/wr_res    : ciphertext result handshake
//   rd_req/rd_data/rd_ack        : decrypt request, ciphertext, 1-cycle accept
//   rd_res_valid/ready/rd_res    : plaintext result handshake
//   enc_start/enc_din            : encrypt core start pulse and input block
//   enc_done/enc_dout            : encrypt core completion and output block
//   dec_start/dec_din            : decrypt core start pulse and input block
//   dec_done/dec_dout            : decrypt core completion and output block
//   busy                         : high in every state except IDLE
//   err_timeout                  : sticky, set when a core fails to finish
//   roundtrip_err                : (AES_ROUNDTRIP_CHECK_EN only) sticky
//                                  round-trip mismatch flag
import aes_sched_pkg::*;

module aes_job_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AES_BLK_W-1:0] key,
    input  logic                 wr_req,
    input  logic [AES_BLK_W-1:0] wr_data,
    output logic                 wr_ack,
    output logic                 wr_res_valid,
    input  logic                 wr_res_ready,
    output logic [AES_BLK_W-1:0] wr_res,
    input  logic                 rd_req,
    input  logic [AES_BLK_W-1:0] rd_data,
    output logic                 rd_ack,
    output logic                 rd_res_valid,
    input  logic                 rd_res_ready,
    output logic [AES_BLK_W-1:0] rd_res,
    output logic                 enc_start,
    output logic [AES_BLK_W-1:0] enc_din,
    input  logic                 enc_done,
    input  logic [AES_BLK_W-1:0] enc_dout,
    output logic                 dec_start,
    output logic [AES_BLK_W-1:0] dec_din,
    input  logic                 dec_done,
    input  logic [AES_BLK_W-1:0] dec_dout,
    output logic                 busy,
    output logic                 err_timeout
`ifdef AES_ROUNDTRIP_CHECK_EN
    ,
    output logic                 roundtrip_err
`endif
);

    sched_state_t state_q, state_d;

    logic                 op_q;
    logic [TO_W-1:0]      cnt_q;
    logic                 done_q;
    logic [AES_BLK_W-1:0] enc_din_q, dec_din_q;
    logic [AES_BLK_W-1:0] wr_res_q, rd_res_q;
    logic                 wr_res_valid_q, rd_res_valid_q;
    logic                 err_timeout_q;
`ifdef AES_ROUNDTRIP_CHECK_EN
    logic                 roundtrip_err_q;
    logic                 v_done;
`endif

    logic [1:0]           arb_gnt;
    logic                 arb_update;

    logic                 sel_done;
    logic [AES_BLK_W-1:0] sel_dout;
    logic                 done_rise;
    logic                 cnt_last;

    logic                 arm;
    logic                 tick;
    logic                 op_done;
    logic                 op_to;
    logic                 handshake;

    // The key bypasses this block; it is listed here only so the port set
    // mirrors the core interface.
    logic unused_key;
    assign unused_key = ^key;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({rd_req, wr_req}),
        .update (arb_update),
        .grant  (arb_gnt)
    );

    assign arb_update = (state_q == IDLE);

    // Done/Dout of whichever core the current phase is waiting on.
    always_comb begin
        if (op_q == OP_DEC) begin
            sel_done = dec_done;
            sel_dout = dec_dout;
        end else begin
            sel_done = enc_done;
            sel_dout = enc_dout;
        end
`ifdef AES_ROUNDTRIP_CHECK_EN
        if ((state_q == VSTART) || (state_q == VWAIT)) begin
            sel_done = dec_done;
            sel_dout = dec_dout;
        end
`endif
    end

    // Edge detect so a done left high by the previous op is not taken as
    // completion of the new one.
    assign done_rise = sel_done && !done_q;
    assign cnt_last  = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        enc_start = 1'b0;
        dec_start = 1'b0;
        arm       = 1'b0;
        tick      = 1'b0;
        op_done   = 1'b0;
        op_to     = 1'b0;
        handshake = 1'b0;
`ifdef AES_ROUNDTRIP_CHECK_EN
        v_done    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_gnt[0]) begin
                    wr_ack  = 1'b1;
                    state_d = START;
                end else if (arb_gnt[1]) begin
                    rd_ack  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                arm = 1'b1;
                if (op_q == OP_ENC) begin
                    enc_start = 1'b1;
                end else begin
                    dec_start = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                tick = 1'b1;
                if (done_rise) begin
                    op_done = 1'b1;
`ifdef AES_ROUNDTRIP_CHECK_EN
                    state_d = (op_q == OP_ENC) ? VSTART : RESULT;
`else
                    state_d = RESULT;
`endif
                end else if (cnt_last) begin
                    op_to   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (op_q == OP_ENC) begin
                    handshake = wr_res_ready && wr_res_valid_q;
                end else begin
                    handshake = rd_res_ready && rd_res_valid_q;
                end
                if (handshake) begin
                    state_d = IDLE;
                end
            end
`ifdef AES_ROUNDTRIP_CHECK_EN
            VSTART: begin
                arm       = 1'b1;
                dec_start = 1'b1;
                state_d   = VWAIT;
            end
            VWAIT: begin
                tick = 1'b1;
                if (done_rise) begin
                    v_done  = 1'b1;
                    state_d = RESULT;
                end else if (cnt_last) begin
                    op_to   = 1'b1;
                    state_d = RESULT;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q            <= OP_ENC;
            cnt_q           <= '0;
            done_q          <= 1'b0;
            enc_din_q       <= '0;
            dec_din_q       <= '0;
            wr_res_q        <= '0;
            rd_res_q        <= '0;
            wr_res_valid_q  <= 1'b0;
            rd_res_valid_q  <= 1'b0;
            err_timeout_q   <= 1'b0;
`ifdef AES_ROUNDTRIP_CHECK_EN
            roundtrip_err_q <= 1'b0;
`endif
        end else begin
            if (wr_ack) begin
                op_q      <= OP_ENC;
                enc_din_q <= wr_data;
            end
            if (rd_ack) begin
                op_q      <= OP_DEC;
                dec_din_q <= rd_data;
            end

            if (arm) begin
                cnt_q  <= '0;
                done_q <= sel_done;
            end
            if (tick) begin
                cnt_q  <= cnt_q + TO_W'(1);
                done_q <= sel_done;
            end

            if (op_done) begin
                if (op_q == OP_ENC) begin
                    wr_res_q <= sel_dout;
`ifdef AES_ROUNDTRIP_CHECK_EN
                    // ciphertext goes back through the decrypt core before
                    // the write path sees it
                    dec_din_q <= sel_dout;
`else
                    wr_res_valid_q <= 1'b1;
`endif
                end else begin
                    rd_res_q       <= sel_dout;
                    rd_res_valid_q <= 1'b1;
                end
            end

`ifdef AES_ROUNDTRIP_CHECK_EN
            if (v_done) begin
                wr_res_valid_q <= 1'b1;
                if (sel_dout != enc_din_q) begin
                    roundtrip_err_q <= 1'b1;
                end
            end
`endif

            if (op_to) begin
                err_timeout_q <= 1'b1;
                if (op_q == OP_ENC) begin
                    wr_res_q       <= '0;
                    wr_res_valid_q <= 1'b1;
                end else begin
                    rd_res_q       <= '0;
                    rd_res_valid_q <= 1'b1;
                end
            end

            if (handshake) begin
                if (op_q == OP_ENC) begin
                    wr_res_valid_q <= 1'b0;
                end else begin
                    rd_res_valid_q <= 1'b0;
                end
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign enc_din      = enc_din_q;
    assign dec_din      = dec_din_q;
    assign wr_res       = wr_res_q;
    assign rd_res       = rd_res_q;
    assign wr_res_valid = wr_res_valid_q;
    assign rd_res_valid = rd_res_valid_q;
    assign err_timeout  = err_timeout_q;
`ifdef AES_ROUNDTRIP_CHECK_EN
    assign roundtrip_err = roundtrip_err_q;
`endif

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler
//   Self-checking bench for aes_job_scheduler (default build). Behavioural
//   stand-ins for the cores: encrypt returns ~din after 12 cycles, decrypt
//   returns din ^ {16{8'hA5}} after 8 cycles. Expected results are literal
//   constants worked out from those transforms.
module tb_aes_job_scheduler;

    localparam int TOC  = 16;
    localparam int TOW  = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key   = 128'h00112233445566778899AABBCCDDEEFF;
    logic         wr_req = 1'b0, rd_req = 1'b0;
    logic [127:0] wr_data = '0, rd_data = '0;
    logic         wr_ack, rd_ack, wr_res_valid, rd_res_valid;
    logic         wr_res_ready = 1'b0, rd_res_ready = 1'b0;
    logic [127:0] wr_res, rd_res;
    logic         enc_start, dec_start;
    logic [127:0] enc_din, dec_din;
    logic         enc_done = 1'b0, dec_done = 1'b0;
    logic [127:0] enc_dout = '0, dec_dout = '0;
    logic         busy, err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    aes_job_scheduler #(.TIMEOUT_CYCLES(TOC), .TO_W(TOW)) dut (
        .clock(clock), .reset(reset), .key(key),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .wr_res_valid(wr_res_valid), .wr_res_ready(wr_res_ready), .wr_res(wr_res),
        .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
        .rd_res_valid(rd_res_valid), .rd_res_ready(rd_res_ready), .rd_res(rd_res),
        .enc_start(enc_start), .enc_din(enc_din), .enc_done(enc_done), .enc_dout(enc_dout),
        .dec_start(dec_start), .dec_din(dec_din), .dec_done(dec_done), .dec_dout(dec_dout),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural cores ----------------
    int  enc_cnt = 0, dec_cnt = 0;
    int  enc_lat = 12, dec_lat = 8;
    bit  enc_hold = 1'b0, dec_never = 1'b0;
    logic [127:0] dec_mask = {16{8'hA5}};

    always @(negedge clock) begin
        if (enc_start) begin
            enc_cnt = enc_lat;
            if (!enc_hold) enc_done = 1'b0;
        end else if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_hold && enc_cnt == 3) enc_done = 1'b0;
            if (enc_cnt == 0) begin
                enc_done = 1'b1;
                enc_dout = ~enc_din;
            end
        end else if (!enc_hold) begin
            enc_done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (dec_start) begin
            dec_cnt  = dec_lat;
            dec_done = 1'b0;
        end else if (dec_cnt > 0) begin
            dec_cnt--;
            if (dec_cnt == 0 && !dec_never) begin
                dec_done = 1'b1;
                dec_dout = dec_din ^ dec_mask;
            end
        end else begin
            dec_done = 1'b0;
        end
    end

    // start pulse monitors
    int enc_starts = 0, dec_starts = 0, both_hi = 0;
    always @(posedge clock) begin
        if (enc_start) enc_starts++;
        if (dec_start) dec_starts++;
        if (enc_start && dec_start) both_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input bit is_dec, output bit got);
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (is_dec ? rd_ack : wr_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_valid(input bit is_dec, output bit got);
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (is_dec ? rd_res_valid : wr_res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic take_result(input bit is_dec);
        if (is_dec) rd_res_ready = 1'b1; else wr_res_ready = 1'b1;
        @(negedge clock);
        rd_res_ready = 1'b0;
        wr_res_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enc_cnt = 0; dec_cnt = 0; enc_done = 1'b0; dec_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic run_op(input bit is_dec, input logic [127:0] din,
                          input logic [127:0] exp, input string nm);
        bit got;
        @(negedge clock);
        enc_starts = 0; dec_starts = 0;
        if (is_dec) begin rd_req = 1'b1; rd_data = din; end
        else        begin wr_req = 1'b1; wr_data = din; end
        #1;
        wait_ack(is_dec, got);
        check({nm, "_ack"}, got, 1);
        @(negedge clock);
        check({nm, "_ack_pulse"}, is_dec ? rd_ack : wr_ack, 0);
        rd_req = 1'b0; wr_req = 1'b0;
        wait_valid(is_dec, got);
        check({nm, "_valid"}, got, 1);
        check({nm, "_res"}, is_dec ? rd_res : wr_res, exp);
        check({nm, "_starts"}, {enc_starts, dec_starts},
              is_dec ? {32'd0, 32'd1} : {32'd1, 32'd0});
        take_result(is_dec);
        check({nm, "_idle"}, {busy, wr_res_valid, rd_res_valid}, 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit           is_dec;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        bit got;
        int n;
        int bp_bad;
        logic [127:0] held;
        logic [3:0] rr_exp;

        vecs[0] = '{1'b0, 128'h0000_0000_0000_0000_0000_0000_0000_3232,
                          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_CDCD};
        vecs[1] = '{1'b1, 128'h0,
                          128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5};
        vecs[2] = '{1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0};
        vecs[3] = '{1'b1, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 128'h0};
        vecs[4] = '{1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                          128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF};
        vecs[5] = '{1'b1, 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A,
                          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};

        // reset state
        @(negedge clock);
        check("rst_ctrl", {wr_ack, rd_ack, wr_res_valid, rd_res_valid,
                           enc_start, dec_start, busy, err_timeout}, 0);
        check("rst_data", wr_res | rd_res | enc_din | dec_din, 0);
        reset = 1'b0;
        @(negedge clock);

        // single operations from the table
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].is_dec, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

        // stale done: encrypt core leaves done high after its result
        enc_hold = 1'b1;
        run_op(1'b0, 128'h1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, "stale_op1");
        wr_req = 1'b1; wr_data = 128'h2;
        #1;
        wait_ack(1'b0, got);
        check("stale_ack", got, 1);
        @(negedge clock);
        wr_req = 1'b0;
        repeat (5) @(negedge clock);
        check("stale_done_high", enc_done, 1);
        check("stale_ignored", {wr_res_valid, busy}, 2'b01);
        wait_valid(1'b0, got);
        check("stale_valid", got, 1);
        check("stale_res", wr_res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD);
        take_result(1'b0);
        enc_hold = 1'b0;
        enc_done = 1'b0;

        // round robin with both requests held, from reset
        do_reset();
        rr_exp = 4'b1010;
        wr_req = 1'b1; wr_data = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        rd_req = 1'b1; rd_data = 128'h0;
        #1;
        for (int g = 0; g < 4; g++) begin
            bit side;
            side = 1'b0;
            got  = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (wr_ack) begin side = 1'b0; got = 1'b1; break; end
                if (rd_ack) begin side = 1'b1; got = 1'b1; break; end
                @(negedge clock);
            end
            check($sformatf("rr_ack%0d", g), got, 1);
            check($sformatf("rr_side%0d", g), side, rr_exp[g]);
            wait_valid(side, got);
            if (side)
                check($sformatf("rr_res%0d", g), rd_res,
                      128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
            else
                check($sformatf("rr_res%0d", g), wr_res,
                      128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE);
            take_result(side);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clock);

        // backpressure: result held while rd_req waits
        wr_req = 1'b1; wr_data = 128'hCAFE;
        #1;
        wait_ack(1'b0, got);
        @(negedge clock);
        wr_req = 1'b0;
        wait_valid(1'b0, got);
        check("bp_valid", got, 1);
        held = wr_res;
        check("bp_res", held, ~(128'hCAFE));
        rd_req = 1'b1; rd_data = 128'h5A5A;
        bp_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (wr_res !== held || rd_ack !== 1'b0 || wr_res_valid !== 1'b1) bp_bad++;
        end
        check("bp_stable", bp_bad, 0);
        take_result(1'b0);
        check("bp_rd_ack_after", rd_ack, 1);
        @(negedge clock);
        rd_req = 1'b0;
        wait_valid(1'b1, got);
        check("bp_rd_res", rd_res, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_FFFF);
        take_result(1'b1);

        // timeout: decrypt core never answers
        dec_never = 1'b1;
        rd_req = 1'b1; rd_data = 128'h77;
        #1;
        wait_ack(1'b1, got);
        @(negedge clock);
        rd_req = 1'b0;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            if (rd_res_valid) break;
            @(negedge clock);
            n++;
        end
        check("to_latency", n, 17);
        check("to_flag", {err_timeout, rd_res_valid}, 2'b11);
        check("to_res", rd_res, 0);
        take_result(1'b1);
        dec_never = 1'b0;
        run_op(1'b1, 128'h0, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, "after_to");
        check("to_sticky", err_timeout, 1);

        // reset in the middle of WAIT
        wr_req = 1'b1; wr_data = 128'h3232;
        #1;
        wait_ack(1'b0, got);
        @(negedge clock);
        wr_req = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst_busy_before", busy, 1);
        reset = 1'b1;
        enc_cnt = 0; enc_done = 1'b0;
        #1;
        check("midrst_ctrl", {wr_ack, rd_ack, wr_res_valid, rd_res_valid,
                              enc_start, dec_start, busy, err_timeout}, 0);
        check("midrst_data", wr_res | rd_res | enc_din | dec_din, 0);
        @(negedge clock);
        reset = 1'b0;
        run_op(1'b0, 128'h0000_0000_0000_0000_0000_0000_0000_3232,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_CDCD, "after_rst");
        check("after_rst_err", err_timeout, 0);

        check("start_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
